// File: rtl/disp_pkg.sv
// disp_pkg: shared digit/word widths, scheduler state encoding and blank-mask helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package disp_pkg;

  localparam int DIGIT_W = 4;
  localparam int WORD_W  = 16;
  localparam int NDIGITS = 4;

  typedef enum logic [1:0] {IDLE, SHOW, GAP} disp_state_t;

  typedef logic [WORD_W-1:0]  disp_word_t;
  typedef logic [NDIGITS-1:0] disp_mask_t;

  localparam disp_mask_t BLANK_ALL = '1;

  // Leading-zero mask: a digit is off only if it and every more significant digit are zero.
  // Digit 0 always stays lit so a zero word still shows "0".
  function automatic disp_mask_t lz_blank_mask(input disp_word_t w);
    disp_mask_t m;
    m[3] = (w[15:12] == 4'h0);
    m[2] = m[3] & (w[11:8] == 4'h0);
    m[1] = m[2] & (w[7:4] == 4'h0);
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/display_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin pick of the first requester after ptr, wrapping modulo N.
// Latency: 0 (purely combinational).
// Backpressure: none; the caller decides when to consume the result.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  // Walk ptr+1 .. ptr+N (mod N); the first set request wins.
  always_comb begin
    int            j;
    logic [IW-1:0] jj;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    jj    = '0;
    for (int k = 1; k <= N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!any && req[jj]) begin
        any       = 1'b1;
        grant[jj] = 1'b1;
        idx       = jj;
      end
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// display_scheduler: round-robin time-share of the 4-digit hex display with min dwell and blank gap.
// Latency: 1 clk from src_req/src_data to registered digits, blank mask and grant.
// Backpressure: none; requests are level-held and simply wait out the current dwell and gap.
// Build option: define DISP_LZ_BLANK_EN to blank leading zero digits while a source is shown.
module display_scheduler
  import disp_pkg::*;
#(
  parameter int NSRC         = 4,
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int BLANK_CYCLES = 5_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NSRC-1:0]         src_req,
  input  logic [WORD_W*NSRC-1:0]  src_data,
  output logic [DIGIT_W-1:0]      d0,
  output logic [DIGIT_W-1:0]      d1,
  output logic [DIGIT_W-1:0]      d2,
  output logic [DIGIT_W-1:0]      d3,
  output logic [NDIGITS-1:0]      blank,
  output logic [NSRC-1:0]         grant,
  output logic [$clog2(NSRC)-1:0] active_idx,
  output logic                    busy
);

  localparam int IW      = $clog2(NSRC);
  localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES - 1);

  disp_state_t     state_q, state_nxt;
  logic [CW-1:0]   cnt_q, cnt_nxt;
  logic [IW-1:0]   ptr_q, ptr_nxt, idx_nxt;
  disp_word_t      word_q, word_nxt, cur_word, win_word;
  disp_mask_t      blank_nxt, show_mask;
  logic [NSRC-1:0] grant_nxt, arb_grant;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;
  logic            take_grant;

  rr_arbiter #(.N(NSRC)) u_arb (
    .req   (src_req),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign cur_word = src_data[WORD_W*active_idx +: WORD_W];
  assign win_word = src_data[WORD_W*arb_idx +: WORD_W];

  // Mask is taken from the digits about to be registered, so blank and dN stay aligned.
`ifdef DISP_LZ_BLANK_EN
  assign show_mask = lz_blank_mask(word_nxt);
`else
  assign show_mask = '0;
`endif

  // Next-state: IDLE/GAP hand out grants, SHOW tracks data live until dwell expiry or drop.
  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    ptr_nxt    = ptr_q;
    word_nxt   = word_q;
    grant_nxt  = grant;
    idx_nxt    = active_idx;
    take_grant = 1'b0;
    unique case (state_q)
      IDLE: begin
        take_grant = arb_any;
      end
      SHOW: begin
        // Leave on an early drop, or at dwell end if anyone else is waiting (or nobody at all).
        if (!src_req[active_idx] || (cnt_q == '0 && (src_req & ~grant) != '0)) begin
          state_nxt = GAP;
          cnt_nxt   = BLANK_LOAD;
          grant_nxt = '0;
        end else begin
          word_nxt = cur_word;
          cnt_nxt  = (cnt_q == '0) ? DWELL_LOAD : cnt_q - 1'b1;
        end
      end
      GAP: begin
        // The gap always runs its full length; late requests wait for the re-arbitration.
        if (cnt_q != '0) begin
          cnt_nxt = cnt_q - 1'b1;
        end else if (arb_any) begin
          take_grant = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (take_grant) begin
      state_nxt = SHOW;
      grant_nxt = arb_grant;
      idx_nxt   = arb_idx;
      ptr_nxt   = arb_idx;
      cnt_nxt   = DWELL_LOAD;
      word_nxt  = win_word;
    end
    blank_nxt = (state_nxt == SHOW) ? show_mask : BLANK_ALL;
  end

  // State, counter, rr pointer and all output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ptr_q      <= IW'(NSRC - 1);
      word_q     <= '0;
      blank      <= BLANK_ALL;
      grant      <= '0;
      active_idx <= '0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      cnt_q      <= cnt_nxt;
      ptr_q      <= ptr_nxt;
      word_q     <= word_nxt;
      blank      <= blank_nxt;
      grant      <= grant_nxt;
      active_idx <= idx_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end

  assign d0 = word_q[0*DIGIT_W +: DIGIT_W];
  assign d1 = word_q[1*DIGIT_W +: DIGIT_W];
  assign d2 = word_q[2*DIGIT_W +: DIGIT_W];
  assign d3 = word_q[3*DIGIT_W +: DIGIT_W];

endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler: directed table and sequence checks of display_scheduler.
// Runs with NSRC=4, DWELL_CYCLES=8, BLANK_CYCLES=2.
// Works with or without DISP_LZ_BLANK_EN defined.
module tb_display_scheduler;

  localparam logic [15:0] W0 = 16'h1A2B;
  localparam logic [15:0] W1 = 16'h2C3D;
  localparam logic [15:0] W2 = 16'h3E4F;
  localparam logic [15:0] W3 = 16'h4567;

`ifdef DISP_LZ_BLANK_EN
  localparam logic [3:0] LZ_00FF = 4'b1100;
  localparam logic [3:0] LZ_0007 = 4'b1110;
  localparam logic [3:0] LZ_0000 = 4'b1110;
  localparam logic [3:0] LZ_0100 = 4'b1000;
`else
  localparam logic [3:0] LZ_00FF = 4'b0000;
  localparam logic [3:0] LZ_0007 = 4'b0000;
  localparam logic [3:0] LZ_0000 = 4'b0000;
  localparam logic [3:0] LZ_0100 = 4'b0000;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  src_req;
  logic [15:0] words [4];
  logic [63:0] src_data;
  logic [3:0]  d0, d1, d2, d3, blank, grant;
  logic [1:0]  active_idx;
  logic        busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  grant;
    logic [3:0]  blank;
    logic        busy;
    logic [1:0]  idx;
    logic [15:0] word;
  } vec_t;

  vec_t tbl[$];

  assign src_data = {words[3], words[2], words[1], words[0]};

  always #5 clk = ~clk;

  display_scheduler #(.NSRC(4), .DWELL_CYCLES(8), .BLANK_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_req    (src_req),
    .src_data   (src_data),
    .d0         (d0),
    .d1         (d1),
    .d2         (d2),
    .d3         (d3),
    .blank      (blank),
    .grant      (grant),
    .active_idx (active_idx),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    check({tag, ".grant"}, 32'(grant), 32'(v.grant));
    check({tag, ".blank"}, 32'(blank), 32'(v.blank));
    check({tag, ".busy"},  32'(busy),  32'(v.busy));
    check({tag, ".idx"},   32'(active_idx), 32'(v.idx));
    check({tag, ".digits"}, 32'({d3, d2, d1, d0}), 32'(v.word));
  endtask

  // Apply req, clock once, check outputs 1 time unit after the edge.
  task automatic step(input string tag, input logic [3:0] req, input logic [3:0] g,
                      input logic [3:0] bl, input logic bz, input logic [1:0] ix,
                      input logic [15:0] w);
    vec_t v;
    v.req = req; v.grant = g; v.blank = bl; v.busy = bz; v.idx = ix; v.word = w;
    src_req = req;
    @(posedge clk);
    #1;
    check_outs(tag, v);
  endtask

  task automatic add(input logic [3:0] req, input logic [3:0] g, input logic [3:0] bl,
                     input logic bz, input logic [1:0] ix, input logic [15:0] w);
    vec_t v;
    v.req = req; v.grant = g; v.blank = bl; v.busy = bz; v.idx = ix; v.word = w;
    tbl.push_back(v);
  endtask

  initial begin
    vec_t rv;

    // Round-robin over sources 0,1,3 with 8-cycle dwell and 2-cycle gaps, then drop to IDLE.
    for (int i = 0; i < 8; i++) add(4'b1011, 4'b0001, 4'b0000, 1'b1, 2'd0, W0);
    for (int i = 0; i < 2; i++) add(4'b1011, 4'b0000, 4'b1111, 1'b1, 2'd0, W0);
    for (int i = 0; i < 8; i++) add(4'b1011, 4'b0010, 4'b0000, 1'b1, 2'd1, W1);
    for (int i = 0; i < 2; i++) add(4'b1011, 4'b0000, 4'b1111, 1'b1, 2'd1, W1);
    for (int i = 0; i < 8; i++) add(4'b1011, 4'b1000, 4'b0000, 1'b1, 2'd3, W3);
    for (int i = 0; i < 2; i++) add(4'b1011, 4'b0000, 4'b1111, 1'b1, 2'd3, W3);
    add(4'b1011, 4'b0001, 4'b0000, 1'b1, 2'd0, W0);
    add(4'b0000, 4'b0000, 4'b1111, 1'b1, 2'd0, W0);
    add(4'b0000, 4'b0000, 4'b1111, 1'b1, 2'd0, W0);
    add(4'b0000, 4'b0000, 4'b1111, 1'b0, 2'd0, W0);
    add(4'b0000, 4'b0000, 4'b1111, 1'b0, 2'd0, W0);

    words[0] = W0; words[1] = W1; words[2] = W2; words[3] = W3;
    src_req = 4'b0000;
    rst_n   = 1'b0;
    #12;
    rv.req = 4'b0000; rv.grant = 4'b0000; rv.blank = 4'b1111; rv.busy = 1'b0;
    rv.idx = 2'd0; rv.word = 16'h0000;
    check_outs("reset", rv);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("idle0", 4'b0000, 4'b0000, 4'b1111, 1'b0, 2'd0, 16'h0000);

    // Table-driven round-robin.
    for (int i = 0; i < tbl.size(); i++) begin
      src_req = tbl[i].req;
      @(posedge clk);
      #1;
      check_outs($sformatf("rr[%0d]", i), tbl[i]);
    end

    // Single source holds the display past dwell with no gap.
    step("single0", 4'b0001, 4'b0001, 4'b0000, 1'b1, 2'd0, W0);
    for (int i = 0; i < 12; i++)
      step($sformatf("single_hold%0d", i), 4'b0001, 4'b0001, 4'b0000, 1'b1, 2'd0, W0);
    step("single_drop0", 4'b0000, 4'b0000, 4'b1111, 1'b1, 2'd0, W0);
    step("single_drop1", 4'b0000, 4'b0000, 4'b1111, 1'b1, 2'd0, W0);
    step("single_idle",  4'b0000, 4'b0000, 4'b1111, 1'b0, 2'd0, W0);

    // Early drop by source 1 on its third dwell cycle, source 2 takes over after the gap.
    words[2] = 16'h00FF;
    step("early0", 4'b0010, 4'b0010, 4'b0000, 1'b1, 2'd1, W1);
    step("early1", 4'b0010, 4'b0010, 4'b0000, 1'b1, 2'd1, W1);
    step("early2", 4'b0010, 4'b0010, 4'b0000, 1'b1, 2'd1, W1);
    step("early_gap0", 4'b0100, 4'b0000, 4'b1111, 1'b1, 2'd1, W1);
    step("early_gap1", 4'b0100, 4'b0000, 4'b1111, 1'b1, 2'd1, W1);
    step("early_next", 4'b0100, 4'b0100, LZ_00FF, 1'b1, 2'd2, 16'h00FF);

    // Live data tracking, no re-grant, and leading-zero mask.
    words[2] = 16'h1234;
    step("live", 4'b0100, 4'b0100, 4'b0000, 1'b1, 2'd2, 16'h1234);
    words[2] = 16'h0007;
    step("lz_0007", 4'b0100, 4'b0100, LZ_0007, 1'b1, 2'd2, 16'h0007);
    words[2] = 16'h0000;
    step("lz_0000", 4'b0100, 4'b0100, LZ_0000, 1'b1, 2'd2, 16'h0000);
    words[2] = 16'h0100;
    step("lz_0100", 4'b0100, 4'b0100, LZ_0100, 1'b1, 2'd2, 16'h0100);

    // Asynchronous reset in the middle of SHOW.
    #2;
    rst_n = 1'b0;
    #1;
    rv.req = 4'b0000; rv.grant = 4'b0000; rv.blank = 4'b1111; rv.busy = 1'b0;
    rv.idx = 2'd0; rv.word = 16'h0000;
    check_outs("arst", rv);
    src_req = 4'b0000;
    @(posedge clk); #1;
    check_outs("arst_hold", rv);
    rst_n = 1'b1;
    step("post_rst0", 4'b0000, 4'b0000, 4'b1111, 1'b0, 2'd0, 16'h0000);
    step("post_rst1", 4'b0000, 4'b0000, 4'b1111, 1'b0, 2'd0, 16'h0000);
    // Pointer is back at NSRC-1, so an all-request picks source 0.
    step("ptr_reset", 4'b1111, 4'b0001, 4'b0000, 1'b1, 2'd0, W0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
